riscv_test_monitor: RTL
=======================

Name: riscv_test_monitor

Overview:
Synthesizable pass/fail monitor for riscv-tests and compliance runs on minisoc. It snoops the core's register-file write port and data-store bus and decodes the test signature. It supports two modes: register-signature (x28/x29 convention) and tohost store. It provides a cycle-accurate watchdog and retire/cycle counters, so results are available in both simulation and FPGA, where a GPIO can report them.

Parameters:
XLEN, 32, data/address width
MODE, 0, 0 = register signature, 1 = tohost store, 2 = both (first event wins)
SIG1_IDX, 28, register index of signature 1
SIG2_IDX, 29, register index of signature 2
TNUM_IDX, 3, register index holding current test case number
PASS_SIG2, 1, signature-2 value meaning PASS (signature 1 must equal 1)
FAIL_SIG2, 2, signature-2 value meaning FAIL (signature 1 must equal 1); must differ from PASS_SIG2
TOHOST_ADDR, 32'h0000_1000, byte address of tohost word
TIMEOUT_CYCLES, 4000, RUN cycles before TIMEOUT; must be >= 2
CNT_W, 32, width of cycle/retire counters

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
clear  in  1  synchronous restart of monitor (same effect as rst)
rf_wen  in  1  register file write enable
rf_waddr  in  5  register file write index
rf_wdata  in  XLEN  register file write data
st_valid  in  1  data store accepted this cycle
st_addr  in  XLEN  store byte address
st_data  in  XLEN  store data
instr_retire  in  1  one instruction retired this cycle
done  out  1  sticky: a result has been decided
done_pulse  out  1  single-cycle pulse on the cycle done rises
pass  out  1  sticky PASS
fail  out  1  sticky FAIL
timeout  out  1  sticky TIMEOUT
test_num  out  XLEN  failing/last test case number
cycle_cnt  out  CNT_W  RUN cycles elapsed
retire_cnt  out  CNT_W  instructions retired in RUN

Behaviour:
- Ports clk and rst: one clock; reset is synchronous and active-high. rst has priority over clear; both act identically.
- Reset values: all outputs 0; shadow registers sig1/sig2/tnum = 0; FSM state = RUN.
- Shadow tracking: on rf_wen with rf_waddr matching SIG1_IDX/SIG2_IDX/TNUM_IDX, the shadow is updated at the next edge. Writes to index 0 are ignored. Shadows update only in RUN.
- FSM states: RUN, PASS, FAIL, TIMEOUT. PASS/FAIL/TIMEOUT are terminal until rst/clear.
- Register-mode evaluation, combinational on shadows while in RUN:
  - sig1==1 && sig2==PASS_SIG2 -> PASS.
  - sig1==1 && sig2==FAIL_SIG2 -> FAIL.
  - Latency: two edges from the signature write to pass/done high (shadow edge + state edge).
- Tohost-mode evaluation: st_valid && st_addr==TOHOST_ADDR && st_data[0]==1.
  - st_data==1 -> PASS.
  - Else FAIL with test_num = st_data >> 1.
  - Latency: one edge.
  - Stores with st_data[0]==0 are ignored.
- test_num: in register mode, captured from tnum shadow on entering FAIL or TIMEOUT; 0 on PASS.
- Counters:
  - cycle_cnt increments every RUN cycle; retire_cnt increments on instr_retire in RUN.
  - Both freeze on leaving RUN and saturate at all-ones.
- Timeout: if in RUN with cycle_cnt == TIMEOUT_CYCLES-1 and no pass/fail condition this cycle -> TIMEOUT.
- Priority on the same cycle: FAIL > PASS > TIMEOUT. In MODE 2, a tohost event and a register event in the same cycle resolve by the same priority; tohost supplies test_num if FAIL.
- Outputs in terminal states:
  - done=1 in any terminal state; exactly one of pass/fail/timeout = 1.
  - done_pulse=1 only on the first terminal cycle.
- Inputs after a terminal state are ignored (shadows, counters, result frozen).
- clear while terminal: next cycle all state is as after reset, back in RUN.

Test Plan:
- MODE0: write x3=5, x28=1, x29=1 on consecutive cycles -> pass=1, done_pulse single cycle two edges after x29 write, test_num=0, fail=timeout=0.
- MODE0: x3=7, x28=1, x29=2 -> fail=1, test_num=7. A later x29=1 write leaves fail=1, pass=0.
- MODE1: store 0x1000 data 0x0000000B -> fail=1, test_num=5 one edge later. Separate run: store data 0x1 -> pass=1. Store to 0x1004 data 1 -> no effect.
- Timeout: TIMEOUT_CYCLES=16, no signature writes, instr_retire every other cycle -> timeout=1 when cycle_cnt=15, retire_cnt=8, counters frozen after.
- Same-cycle: MODE2, tohost store data 0x7 on the cycle register PASS becomes true -> fail=1, test_num=3. Timeout on the same cycle as PASS -> pass=1.
- Writes to x0, and rst asserted mid-run (cycle 10) -> all outputs 0 next cycle, cycle_cnt restarts from 0. clear in FAIL -> returns to RUN, done=0.

Source files
------------

// File: rtl/riscv_test_monitor.sv
// Pass/fail monitor for riscv-tests runs: snoops register-file writes and the store
// bus, decodes the test signature, and runs a watchdog with cycle/retire counters.
module riscv_test_monitor #(
    parameter int unsigned     XLEN           = 32,
    parameter int unsigned     MODE           = 0,
    parameter int unsigned     SIG1_IDX       = 28,
    parameter int unsigned     SIG2_IDX       = 29,
    parameter int unsigned     TNUM_IDX       = 3,
    parameter logic [XLEN-1:0] PASS_SIG2      = XLEN'(1),
    parameter logic [XLEN-1:0] FAIL_SIG2      = XLEN'(2),
    parameter logic [XLEN-1:0] TOHOST_ADDR    = XLEN'(32'h0000_1000),
    parameter int unsigned     TIMEOUT_CYCLES = 4000,
    parameter int unsigned     CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             rf_wen,
    input  logic [4:0]       rf_waddr,
    input  logic [XLEN-1:0]  rf_wdata,
    input  logic             st_valid,
    input  logic [XLEN-1:0]  st_addr,
    input  logic [XLEN-1:0]  st_data,
    input  logic             instr_retire,
    output logic             done,
    output logic             done_pulse,
    output logic             pass,
    output logic             fail,
    output logic             timeout,
    output logic [XLEN-1:0]  test_num,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [1:0] {StRun, StPass, StFail, StTimeout} state_e;

    localparam bit               RegEn       = (MODE != 1);
    localparam bit               ThEn        = (MODE != 0);
    localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntMax      = '1;

    state_e           state_q, state_d;
    logic [XLEN-1:0]  sig1_q, sig1_d;
    logic [XLEN-1:0]  sig2_q, sig2_d;
    logic [XLEN-1:0]  tnum_q, tnum_d;
    logic [XLEN-1:0]  test_num_q, test_num_d;
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] retire_q, retire_d;
    logic             done_pulse_q, done_pulse_d;

    logic rf_wr, reg_pass, reg_fail, th_hit, th_pass, th_fail;

    assign rf_wr    = rf_wen && (rf_waddr != 5'd0);
    assign reg_pass = RegEn && (sig1_q == XLEN'(1)) && (sig2_q == PASS_SIG2);
    assign reg_fail = RegEn && (sig1_q == XLEN'(1)) && (sig2_q == FAIL_SIG2);
    // Only odd tohost values mean "finished"; even ones are other host requests.
    assign th_hit   = ThEn && st_valid && (st_addr == TOHOST_ADDR) && st_data[0];
    assign th_pass  = th_hit && (st_data == XLEN'(1));
    assign th_fail  = th_hit && (st_data != XLEN'(1));

    always_comb begin
        state_d      = state_q;
        sig1_d       = sig1_q;
        sig2_d       = sig2_q;
        tnum_d       = tnum_q;
        test_num_d   = test_num_q;
        cycle_d      = cycle_q;
        retire_d     = retire_q;
        done_pulse_d = 1'b0;

        if (state_q == StRun) begin
            if (rf_wr && (rf_waddr == 5'(SIG1_IDX))) sig1_d = rf_wdata;
            if (rf_wr && (rf_waddr == 5'(SIG2_IDX))) sig2_d = rf_wdata;
            if (rf_wr && (rf_waddr == 5'(TNUM_IDX))) tnum_d = rf_wdata;

            if (reg_fail || th_fail) begin
                state_d    = StFail;
                test_num_d = th_fail ? (st_data >> 1) : tnum_q;
            end else if (reg_pass || th_pass) begin
                state_d    = StPass;
                test_num_d = '0;
            end else if (cycle_q == TimeoutLast) begin
                state_d    = StTimeout;
                test_num_d = tnum_q;
            end else begin
                // Counters only advance on cycles that stay in RUN, so they freeze
                // at the values seen on the deciding cycle.
                if (cycle_q != CntMax) cycle_d = cycle_q + 1'b1;
                if (instr_retire && (retire_q != CntMax)) retire_d = retire_q + 1'b1;
            end

            done_pulse_d = (state_d != StRun);
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q      <= StRun;
            sig1_q       <= '0;
            sig2_q       <= '0;
            tnum_q       <= '0;
            test_num_q   <= '0;
            cycle_q      <= '0;
            retire_q     <= '0;
            done_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sig1_q       <= sig1_d;
            sig2_q       <= sig2_d;
            tnum_q       <= tnum_d;
            test_num_q   <= test_num_d;
            cycle_q      <= cycle_d;
            retire_q     <= retire_d;
            done_pulse_q <= done_pulse_d;
        end
    end

    assign done       = (state_q != StRun);
    assign done_pulse = done_pulse_q;
    assign pass       = (state_q == StPass);
    assign fail       = (state_q == StFail);
    assign timeout    = (state_q == StTimeout);
    assign test_num   = test_num_q;
    assign cycle_cnt  = cycle_q;
    assign retire_cnt = retire_q;

endmodule
